// File: rtl/qpu_pkg.sv
// Shared constants, types and helpers for the QPU measurement readout path.
package qpu_pkg;

  localparam int          AMP_W        = 8;
  localparam int          NORM_AMP     = 10;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting register: q[15],q[13],q[12],q[10]
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  typedef logic [1:0] basis_t;

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    DRAW,
    SCAN,
    DONE
  } state_e;

  function automatic logic [4*AMP_W-1:0] collapse_vec(input basis_t sel);
    logic [4*AMP_W-1:0] vec;
    vec = '0;
    vec[(3 - int'(sel))*AMP_W +: AMP_W] = AMP_W'(NORM_AMP);
    return vec;
  endfunction

endpackage

// File: rtl/qpu_measure_unit_if.sv
// Request/result bundle between the measurement unit and its controller.
interface qpu_measure_unit_if;
  import qpu_pkg::*;

  logic [4*AMP_W-1:0] state_flat;
  logic               meas_req;
  logic               meas_busy;
  logic               seed_load;
  logic [15:0]        seed;
  logic               result_valid;
  logic               result_ready;
  basis_t             result;
  logic               zero_norm_err;
  logic [4*AMP_W-1:0] collapsed_flat;

  modport master (
    output state_flat, meas_req, seed_load, seed, result_ready,
    input  meas_busy, result_valid, result, zero_norm_err, collapsed_flat
  );

  modport slave (
    input  state_flat, meas_req, seed_load, seed, result_ready,
    output meas_busy, result_valid, result, zero_norm_err, collapsed_flat
  );

endinterface

// File: rtl/qpu_lfsr16.sv
// Seedable 16-bit Fibonacci LFSR; a zero seed is replaced by the default seed.
module qpu_lfsr16
  import qpu_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= SEED;
    end else if (load) begin
      q <= (seed == '0) ? SEED : seed;
    end else if (advance) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/qpu_measure_unit.sv
// Projective measurement of a 2-qubit real state vector: square, draw, scan, collapse.
module qpu_measure_unit
  import qpu_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input logic               clk,
  input logic               reset,
  qpu_measure_unit_if.slave bus
);

  localparam int PW = 2*AMP_W;
  localparam int TW = 2*AMP_W + 2;

  state_e                   state, state_next;
  logic signed [AMP_W-1:0]  amp  [4];
  logic        [PW-1:0]     prob [4];
  logic        [TW-1:0]     total, cum, thr;
  basis_t                   idx, sel;
  logic                     found;
  basis_t                   result_q;
  logic                     err_q;
  logic        [4*AMP_W-1:0] coll_q;
  logic        [15:0]       lfsr_q;
  logic                     lfsr_advance;

  logic signed [PW-1:0]     amp_ext;
  logic        [PW-1:0]     square;
  logic        [TW-1:0]     cum_sum;
  logic                     hit;
  logic        [TW+15:0]    draw_prod;
  basis_t                   final_sel;

  assign lfsr_advance = (state == DRAW);

  qpu_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (bus.seed_load),
    .seed    (bus.seed),
    .advance (lfsr_advance),
    .q       (lfsr_q)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.meas_req) state_next = SQUARE;
      SQUARE:  if (idx == 2'd3) state_next = DRAW;
      DRAW:    state_next = SCAN;
      SCAN:    if (idx == 2'd3) state_next = DONE;
      DONE:    if (bus.result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // thr = (r*total)>>16 keeps thr < total, so the scan always finds a winner when total > 0
  always_comb begin
    amp_ext   = PW'(amp[idx]);
    square    = amp_ext * amp_ext;
    cum_sum   = cum + TW'(prob[idx]);
    hit       = cum_sum > thr;
    draw_prod = (TW+16)'(lfsr_q) * (TW+16)'(total);
    final_sel = found ? sel : idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      for (int unsigned i = 0; i < 4; i++) begin
        amp[i]  <= '0;
        prob[i] <= '0;
      end
      total    <= '0;
      cum      <= '0;
      thr      <= '0;
      idx      <= '0;
      sel      <= '0;
      found    <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      coll_q   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.meas_req) begin
            for (int unsigned i = 0; i < 4; i++) begin
              amp[i] <= bus.state_flat[(3 - i)*AMP_W +: AMP_W];
            end
            total <= '0;
            idx   <= '0;
          end
        end
        SQUARE: begin
          prob[idx] <= square;
          total     <= total + TW'(square);
          idx       <= idx + 2'd1;
        end
        DRAW: begin
          thr   <= draw_prod[TW+15:16];
          cum   <= '0;
          found <= 1'b0;
          idx   <= '0;
        end
        SCAN: begin
          cum <= cum_sum;
          idx <= idx + 2'd1;
          if (!found && hit) begin
            found <= 1'b1;
            sel   <= idx;
          end
          if (idx == 2'd3) begin
            if (total == '0) begin
              result_q <= '0;
              err_q    <= 1'b1;
              coll_q   <= '0;
            end else begin
              result_q <= final_sel;
              err_q    <= 1'b0;
              coll_q   <= collapse_vec(final_sel);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.meas_busy      = (state != IDLE);
  assign bus.result_valid   = (state == DONE);
  assign bus.result         = result_q;
  assign bus.zero_norm_err  = err_q;
  assign bus.collapsed_flat = coll_q;

endmodule

// File: tb/tb_qpu_measure_unit.sv
// Bench for qpu_measure_unit: directed table, corner sequences, randomized against a reference model.
module tb_qpu_measure_unit;
  import qpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  qpu_measure_unit_if bus ();

  qpu_measure_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] st;
    logic [15:0] seed;
    basis_t      res;
    logic        err;
    logic [31:0] coll;
    int          hold;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // Probability-proportional pick: first index whose running sum of squares exceeds thr
  function automatic void model(input logic [31:0] st, input logic [15:0] r,
                                output basis_t res, output logic err, output logic [31:0] coll);
    longint p [4];
    longint tot, thr, cum;
    int     a;
    bit     done;
    tot = 0; cum = 0; done = 0;
    res = '0; err = 1'b0; coll = '0;
    for (int i = 0; i < 4; i++) begin
      a = $signed(st[31-8*i -: 8]);
      p[i] = a * a;
      tot += p[i];
    end
    if (tot == 0) begin
      err = 1'b1;
    end else begin
      thr = (longint'(r) * tot) >>> 16;
      for (int i = 0; i < 4; i++) begin
        cum += p[i];
        if (!done && cum > thr) begin
          res  = basis_t'(i);
          done = 1;
        end
      end
      coll[31-8*int'(res) -: 8] = 8'd10;
    end
  endfunction

  task automatic load_seed(input logic [15:0] s);
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed      = s;
    @(posedge clk);
    #1;
    bus.seed_load = 1'b0;
    m_lfsr = (s == 16'h0) ? 16'hACE1 : s;
  endtask

  task automatic accept(input logic [31:0] st);
    @(negedge clk);
    bus.state_flat = st;
    bus.meas_req   = 1'b1;
    @(posedge clk);
    #1;
    bus.meas_req = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.result_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("valid_timeout", 32'(bus.result_valid), 32'd1);
  endtask

  task automatic finish_result(input basis_t r, input logic e, input logic [31:0] c, input int hold);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.result_valid), 32'd1);
      check("hold_busy", 32'(bus.meas_busy), 32'd1);
      check("hold_result", 32'(bus.result), 32'(r));
      check("hold_err", 32'(bus.zero_norm_err), 32'(e));
      check("hold_coll", bus.collapsed_flat, c);
    end
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    check("idle_busy", 32'(bus.meas_busy), 32'd0);
    check("idle_valid", 32'(bus.result_valid), 32'd0);
    check("kept_result", 32'(bus.result), 32'(r));
    check("kept_coll", bus.collapsed_flat, c);
  endtask

  task automatic measure(input string tag, input logic [31:0] st, input basis_t r,
                         input logic e, input logic [31:0] c, input int hold);
    int lat;
    accept(st);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_result"}, 32'(bus.result), 32'(r));
    check({tag, "_err"}, 32'(bus.zero_norm_err), 32'(e));
    check({tag, "_coll"}, bus.collapsed_flat, c);
    m_lfsr = lfsr_next(m_lfsr);
    finish_result(r, e, c, hold);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    basis_t      r;
    logic        e;
    logic [31:0] c;
    logic [31:0] st;
    int          lat;

    vecs[0] = '{32'h0A000000, 16'h1234, 2'd0, 1'b0, 32'h0A000000, 0};
    vecs[1] = '{32'h0000FB00, 16'h5A5A, 2'd2, 1'b0, 32'h00000A00, 1};
    vecs[2] = '{32'h05050505, 16'hFFFF, 2'd3, 1'b0, 32'h0000000A, 0};
    vecs[3] = '{32'h05050505, 16'h8000, 2'd2, 1'b0, 32'h00000A00, 0};
    vecs[4] = '{32'h05050505, 16'h0001, 2'd0, 1'b0, 32'h0A000000, 0};
    vecs[5] = '{32'h00000000, 16'h0000, 2'd0, 1'b1, 32'h00000000, 5};
    vecs[6] = '{32'h00070000, 16'h9999, 2'd1, 1'b0, 32'h000A0000, 2};
    vecs[7] = '{32'h00000080, 16'hFFFF, 2'd3, 1'b0, 32'h0000000A, 0};

    bus.state_flat   = '0;
    bus.meas_req     = 1'b0;
    bus.seed_load    = 1'b0;
    bus.seed         = '0;
    bus.result_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(bus.meas_busy), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_err", 32'(bus.zero_norm_err), 32'd0);
    check("rst_coll", bus.collapsed_flat, 32'd0);

    for (int i = 0; i < 8; i++) begin
      load_seed(vecs[i].seed);
      measure($sformatf("vec%0d", i), vecs[i].st, vecs[i].res, vecs[i].err, vecs[i].coll, vecs[i].hold);
    end

    // Snapshot isolation and meas_req ignored while busy
    load_seed(16'h8000);
    model(32'h05050505, m_lfsr, r, e, c);
    accept(32'h05050505);
    bus.state_flat = 32'h00000009;
    repeat (6) @(posedge clk);
    #1;
    bus.meas_req = 1'b1;
    wait_valid(lat);
    check("snap_result", 32'(bus.result), 32'(r));
    check("snap_coll", bus.collapsed_flat, c);
    @(posedge clk);
    #1;
    check("snap_done_busy", 32'(bus.meas_busy), 32'd1);
    bus.meas_req = 1'b0;
    m_lfsr = lfsr_next(m_lfsr);
    finish_result(r, e, c, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("snap_no_restart", 32'(bus.meas_busy), 32'd0);
    end

    // Seed load coinciding with the draw edge
    load_seed(16'h0001);
    model(32'h05050505, m_lfsr, r, e, c);
    accept(32'h05050505);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed      = 16'hFFFF;
    @(posedge clk);
    #1;
    bus.seed_load = 1'b0;
    wait_valid(lat);
    check("drawload_lat", 32'(lat), 32'd4);
    check("drawload_old_result", 32'(bus.result), 32'(r));
    m_lfsr = 16'hFFFF;
    finish_result(r, e, c, 0);
    model(32'h05050505, m_lfsr, r, e, c);
    check("drawload_new_expect", 32'(r), 32'd3);
    measure("drawload_new", 32'h05050505, r, e, c, 0);

    // Reset in the middle of SCAN
    accept(32'h05050505);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.meas_busy), 32'd0);
    check("midrst_valid", 32'(bus.result_valid), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_err", 32'(bus.zero_norm_err), 32'd0);
    check("midrst_coll", bus.collapsed_flat, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_lfsr = 16'hACE1;
    for (int k = 0; k < 2; k++) begin
      model(32'h05050505, m_lfsr, r, e, c);
      measure($sformatf("postrst%0d", k), 32'h05050505, r, e, c, 0);
    end

    // Randomized measurements against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3) == 0)
        load_seed(($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom));
      st = $urandom;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(2) == 0) st[31-8*i -: 8] = 8'h00;
      model(st, m_lfsr, r, e, c);
      measure("rand", st, r, e, c, int'($urandom_range(2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
